// File: rtl/tile_spawner.sv
// tile_spawner: latches a 2048 board, counts empty cells, places a new tile in an
// LFSR-chosen empty cell. Optional 4-tile spawning is enabled with `define SPAWN_FOUR_EN.
//
// state | meaning
// IDLE  | wait for start, latch board_in
// COUNT | scan cells row-major, count empty cells
// PICK  | target = lfsr mod empty_cnt
// PLACE | rescan cells, write tile into the target-th empty cell
// DONE  | publish board_out / spawn coords / full, pulse done
module tile_spawner #(
    parameter int          N    = 4,
    parameter int          W    = 12,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [0:N-1][0:N-1][W-1:0]      board_in,
    output logic [0:N-1][0:N-1][W-1:0]      board_out,
    output logic                            busy,
    output logic                            done,
    output logic                            full,
    output logic [$clog2(N)-1:0]            spawn_row,
    output logic [$clog2(N)-1:0]            spawn_col
);

    localparam int              RW       = $clog2(N);
    localparam int              CW       = $clog2(N * N + 1);
    localparam logic [15:0]     SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [RW-1:0]   LAST_IDX = RW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        PICK,
        PLACE,
        DONE
    } state_t;

    state_t                      state;
    logic [0:N-1][0:N-1][W-1:0]  board_reg;
    logic [RW-1:0]               row, col, next_row, next_col;
    logic [RW-1:0]               hit_row, hit_col;
    logic [CW-1:0]               empty_cnt, match_cnt, target, cnt_next;
    logic                        full_pend;
    logic [15:0]                 lfsr;
    logic                        lfsr_fb;
    logic [W-1:0]                cur_cell, tile_val;
    logic                        cell_empty, last_cell;

    // Fibonacci LFSR, taps 16,14,13,11; free-running in every state
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end

    assign cur_cell   = board_reg[row][col];
    assign cell_empty = (cur_cell == '0);
    assign last_cell  = (row == LAST_IDX) && (col == LAST_IDX);
    assign cnt_next   = empty_cnt + {{(CW-1){1'b0}}, cell_empty};

    always_comb begin
        next_row = row;
        next_col = col;
        if (last_cell) begin
            next_row = '0;
            next_col = '0;
        end else if (col == LAST_IDX) begin
            next_row = row + 1'b1;
            next_col = '0;
        end else begin
            next_col = col + 1'b1;
        end
    end

`ifdef SPAWN_FOUR_EN
    logic tile_four;
    assign tile_val = tile_four ? W'(4) : W'(2);
`else
    assign tile_val = W'(2);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            board_reg <= '0;
            board_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            full      <= 1'b0;
            full_pend <= 1'b0;
            spawn_row <= '0;
            spawn_col <= '0;
            hit_row   <= '0;
            hit_col   <= '0;
            row       <= '0;
            col       <= '0;
            empty_cnt <= '0;
            match_cnt <= '0;
            target    <= '0;
`ifdef SPAWN_FOUR_EN
            tile_four <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        board_reg <= board_in;
                        empty_cnt <= '0;
                        full      <= 1'b0;
                        full_pend <= 1'b0;
                        row       <= '0;
                        col       <= '0;
                        busy      <= 1'b1;
                        state     <= COUNT;
                    end
                end
                COUNT: begin
                    empty_cnt <= cnt_next;
                    row       <= next_row;
                    col       <= next_col;
                    if (last_cell) begin
                        if (cnt_next == '0) begin
                            full_pend <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= PICK;
                        end
                    end
                end
                PICK: begin
                    target    <= CW'(lfsr % {{(16-CW){1'b0}}, empty_cnt});
                    match_cnt <= '0;
                    row       <= '0;
                    col       <= '0;
`ifdef SPAWN_FOUR_EN
                    tile_four <= (lfsr[3:0] == 4'h0);
`endif
                    state     <= PLACE;
                end
                PLACE: begin
                    // full scan with no early exit keeps latency data-independent
                    if (cell_empty) begin
                        if (match_cnt == target) begin
                            board_reg[row][col] <= tile_val;
                            hit_row             <= row;
                            hit_col             <= col;
                        end
                        match_cnt <= match_cnt + 1'b1;
                    end
                    row <= next_row;
                    col <= next_col;
                    if (last_cell) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    board_out <= board_reg;
                    done      <= 1'b1;
                    full      <= full_pend;
                    if (!full_pend) begin
                        spawn_row <= hit_row;
                        spawn_col <= hit_col;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_spawner.sv
// Directed bench for tile_spawner (N=4, W=12) with a reference LFSR and spawn model.
module tb_tile_spawner;

    typedef logic [0:3][0:3][11:0] board_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    board_t     board_in = '0;
    board_t     board_out;
    logic       busy, done, full;
    logic [1:0] spawn_row, spawn_col;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_lfsr;

    tile_spawner #(.N(4), .W(12), .SEED(16'hACE1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .board_in  (board_in),
        .board_out (board_out),
        .busy      (busy),
        .done      (done),
        .full      (full),
        .spawn_row (spawn_row),
        .spawn_col (spawn_col)
    );

    always #5 clk = ~clk;

    // reference LFSR: textbook form bit = l ^ l>>2 ^ l>>3 ^ l>>5, shifted in at the top
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= (m_lfsr >> 1) | (16'((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'h1) << 15);
    end

    function automatic board_t fill(input logic [11:0] v);
        board_t b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r][c] = v;
        return b;
    endfunction

    function automatic int count_nonzero(input board_t b);
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] != 12'd0) n++;
        return n;
    endfunction

    // expected result of one spawn given the LFSR value seen in the PICK cycle
    task automatic model_spawn(input board_t b, input logic [15:0] pick,
                               output board_t eb, output int er, output int ec, output bit ef);
        int cnt = 0;
        int tgt;
        int m = 0;
        logic [11:0] tv;
        eb = b; er = -1; ec = -1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] == 12'd0) cnt++;
        ef = (cnt == 0);
        if (!ef) begin
            tgt = int'(pick) % cnt;
`ifdef SPAWN_FOUR_EN
            tv = (pick[3:0] == 4'h0) ? 12'd4 : 12'd2;
`else
            tv = 12'd2;
`endif
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (b[r][c] == 12'd0) begin
                        if (m == tgt) begin
                            eb[r][c] = tv; er = r; ec = c;
                        end
                        m++;
                    end
        end
    endtask

    // drive one start and wait (bounded) for done; lat = edges from acceptance to done
    task automatic do_spawn(input board_t b, output int lat, output int busy_cnt,
                            output logic [15:0] pick);
        lat = 0; busy_cnt = 0; pick = '0;
        @(negedge clk); board_in = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        if (busy) busy_cnt++;
        while (lat < 100 && !done) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (lat == 16) pick = m_lfsr;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (board_out !== '0) begin bad++; $display("FAIL reset_board got=%h want=0", board_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        total++; if ({spawn_row, spawn_col} !== 4'd0) begin bad++; $display("FAIL reset_spawn got=%0d,%0d want=0,0", spawn_row, spawn_col); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_empty;
        board_t b, eb;
        int lat, bc;
        logic [15:0] pick;
        b = fill(12'd2); b[2][1] = 12'd0;
        eb = b; eb[2][1] = 12'd2;
        do_spawn(b, lat, bc, pick);
        total++; if (lat !== 34) begin bad++; $display("FAIL single_latency got=%0d want=34", lat); end
        total++; if (board_out !== eb) begin bad++; $display("FAIL single_board got=%h want=%h", board_out, eb); end
        total++; if (spawn_row !== 2'd2 || spawn_col !== 2'd1) begin bad++; $display("FAIL single_spawn got=%0d,%0d want=2,1", spawn_row, spawn_col); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL single_full got=%b want=0", full); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_full;
        board_t b;
        int lat, bc;
        logic [15:0] pick;
        b = fill(12'd8);
        do_spawn(b, lat, bc, pick);
        total++; if (lat !== 17) begin bad++; $display("FAIL full_latency got=%0d want=17", lat); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", full); end
        total++; if (board_out !== b) begin bad++; $display("FAIL full_board got=%h want=%h", board_out, b); end
        total++; if (spawn_row !== 2'd2 || spawn_col !== 2'd1) begin bad++; $display("FAIL full_spawn_hold got=%0d,%0d want=2,1", spawn_row, spawn_col); end
        total++; if (bc !== 17) begin bad++; $display("FAIL full_busy_cycles got=%0d want=17", bc); end
    endtask

    task automatic test_empty_board;
        board_t eb;
        int lat, bc, er, ec, idx;
        bit ef;
        logic [15:0] pick;
        do_spawn('0, lat, bc, pick);
        model_spawn('0, pick, eb, er, ec, ef);
        idx = -1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (board_out[r][c] != 12'd0) idx = r * 4 + c;
        total++; if (lat !== 34) begin bad++; $display("FAIL empty_latency got=%0d want=34", lat); end
        total++; if (bc !== 34) begin bad++; $display("FAIL empty_busy_cycles got=%0d want=34", bc); end
        total++; if (count_nonzero(board_out) !== 1) begin bad++; $display("FAIL empty_one_tile got=%0d want=1", count_nonzero(board_out)); end
        total++; if (idx !== int'(pick % 16'd16)) begin bad++; $display("FAIL empty_index got=%0d want=%0d", idx, pick % 16'd16); end
        total++; if (board_out !== eb) begin bad++; $display("FAIL empty_board got=%h want=%h", board_out, eb); end
        total++; if (spawn_row !== 2'(er) || spawn_col !== 2'(ec)) begin bad++; $display("FAIL empty_spawn got=%0d,%0d want=%0d,%0d", spawn_row, spawn_col, er, ec); end
    endtask

    task automatic test_start_while_busy;
        board_t a, ea, got;
        int dones = 0;
        int first = -1;
        a = fill(12'd2); a[0][3] = 12'd0;
        ea = a; ea[0][3] = 12'd2;
        got = '0;
        @(negedge clk); board_in = a; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        for (int lat = 1; lat <= 60; lat++) begin
            @(posedge clk);
            @(negedge clk);
            start = (lat == 4);
            if (lat >= 4) board_in = '0;
            if (done) begin
                dones++;
                if (first < 0) begin first = lat; got = board_out; end
            end
        end
        start = 1'b0;
        total++; if (dones !== 1) begin bad++; $display("FAIL busy_done_count got=%0d want=1", dones); end
        total++; if (first !== 34) begin bad++; $display("FAIL busy_latency got=%0d want=34", first); end
        total++; if (got !== ea) begin bad++; $display("FAIL busy_board got=%h want=%h", got, ea); end
        total++; if (spawn_row !== 2'd0 || spawn_col !== 2'd3) begin bad++; $display("FAIL busy_spawn got=%0d,%0d want=0,3", spawn_row, spawn_col); end
    endtask

    task automatic test_reset_mid;
        board_t eb;
        int lat, bc, er, ec;
        bit ef;
        logic [15:0] pick;
        @(negedge clk); board_in = '0; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (board_out !== '0) begin bad++; $display("FAIL rstmid_board got=%h want=0", board_out); end
        total++; if (busy !== 1'b0 || done !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL rstmid_flags got=%b%b%b want=000", busy, done, full); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b want=0", busy); end
        do_spawn('0, lat, bc, pick);
        model_spawn('0, pick, eb, er, ec, ef);
        total++; if (lat !== 34) begin bad++; $display("FAIL rstmid_latency got=%0d want=34", lat); end
        total++; if (board_out !== eb) begin bad++; $display("FAIL rstmid_board_after got=%h want=%h", board_out, eb); end
    endtask

    task automatic test_back_to_back;
        board_t b, eb;
        int lat, bc, er, ec;
        bit ef;
        logic [15:0] pick;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            do_spawn(b, lat, bc, pick);
            model_spawn(b, pick, eb, er, ec, ef);
            total++; if (board_out !== eb || lat !== 34) begin bad++; $display("FAIL b2b_spawn%0d got=%h lat=%0d want=%h lat=34", i, board_out, lat, eb); end
            total++; if (full !== 1'b0 || count_nonzero(board_out) !== i + 1) begin bad++; $display("FAIL b2b_count%0d got=%0d full=%b want=%0d full=0", i, count_nonzero(board_out), full, i + 1); end
            b = board_out;
        end
        do_spawn(b, lat, bc, pick);
        total++; if (full !== 1'b1 || lat !== 17) begin bad++; $display("FAIL b2b_final_full got=%b lat=%0d want=1 lat=17", full, lat); end
        total++; if (board_out !== b) begin bad++; $display("FAIL b2b_final_board got=%h want=%h", board_out, b); end
    endtask

    initial begin
        test_reset();
        test_single_empty();
        test_full();
        test_empty_board();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
